// File: rtl/dot_product_engine_if.sv
// Start/base request, shared memory read port and result handshake of the
// dot-product engine. The engine takes the master view; the environment
// (requester, vector memory, result consumer) takes the slave view.
interface dot_product_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int ACC_WIDTH  = 19
);
    logic                         start;
    logic [ADDR_WIDTH-1:0]        a_base;
    logic [ADDR_WIDTH-1:0]        b_base;
    logic                         busy;
    logic                         mem_rd_en;
    logic [ADDR_WIDTH-1:0]        mem_rd_addr;
    logic [DATA_WIDTH-1:0]        mem_rd_data;
    logic signed [ACC_WIDTH-1:0]  result;
    logic                         result_valid;
    logic                         result_ready;

    modport master (
        input  start, a_base, b_base, mem_rd_data, result_ready,
        output busy, mem_rd_en, mem_rd_addr, result, result_valid
    );

    modport slave (
        output start, a_base, b_base, mem_rd_data, result_ready,
        input  busy, mem_rd_en, mem_rd_addr, result, result_valid
    );
endinterface

// File: rtl/dot_product_engine.sv
// Fetches A[i], B[i] through one shared read port (one-cycle read latency),
// accumulates the signed products over VEC_LEN elements and offers the sum
// on a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; bases latched, acc/idx cleared on start
// FETCH_A | read A[idx]
// FETCH_B | read B[idx]; A[idx] arrives and is captured into a_reg
// MAC     | B[idx] arrives; accumulate, advance or finish
// DONE    | result_valid high until result_ready
module dot_product_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int VEC_LEN    = 8,
    parameter int ACC_WIDTH  = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dot_product_engine_if.master     bus_io
);
    localparam int IDX_W = $clog2(VEC_LEN) + 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);

    typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, MAC, DONE} state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]        a_base_q, a_base_d;
    logic [ADDR_WIDTH-1:0]        b_base_q, b_base_d;
    logic [DATA_WIDTH-1:0]        a_reg_q, a_reg_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]  result_q, result_d;

    logic                         rd_en;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic [ADDR_WIDTH-1:0]        idx_addr;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;

    // Index offset wraps with the address width, so vectors may cross the top of memory.
    assign idx_addr = ADDR_WIDTH'(idx_q);
    assign prod     = $signed(a_reg_q) * $signed(bus_io.mem_rd_data);
    assign prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            a_reg_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            a_reg_q  <= a_reg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Next-state, datapath update and read-port decode.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        a_reg_d  = a_reg_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_en    = 1'b0;
        rd_addr  = '0;
        case (state_q)
            IDLE: begin
                if (bus_io.start) begin
                    a_base_d = bus_io.a_base;
                    b_base_d = bus_io.b_base;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = FETCH_A;
                end
            end
            FETCH_A: begin
                rd_en   = 1'b1;
                rd_addr = a_base_q + idx_addr;
                state_d = FETCH_B;
            end
            FETCH_B: begin
                rd_en   = 1'b1;
                rd_addr = b_base_q + idx_addr;
                a_reg_d = bus_io.mem_rd_data;
                state_d = MAC;
            end
            MAC: begin
                if (idx_q < IDX_LAST) begin
                    acc_d   = acc_q + prod_ext;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = FETCH_A;
                end else begin
                    result_d = acc_q + prod_ext;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus_io.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_io.mem_rd_en    = rd_en;
    assign bus_io.mem_rd_addr  = rd_addr;
    assign bus_io.busy         = (state_q != IDLE);
    assign bus_io.result_valid = (state_q == DONE);
    assign bus_io.result       = result_q;
endmodule

// File: tb/tb_dot_product_engine.sv
// Directed and randomised checks of the dot-product engine against a
// behavioural memory and a software dot-product model.
module tb_dot_product_engine;
    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [32];
    logic [4:0] rd_log [$];

    dot_product_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .ACC_WIDTH(19)) bus ();

    dot_product_engine #(
        .DATA_WIDTH(8), .ADDR_WIDTH(5), .VEC_LEN(8), .ACC_WIDTH(19)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory, one cycle latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    // Log every read address; flag any nonzero address while reads are off.
    int idle_addr_bad = 0;
    always @(negedge clk) begin
        if (rst_n && bus.mem_rd_en) rd_log.push_back(bus.mem_rd_addr);
        if (!bus.mem_rd_en && bus.mem_rd_addr != 5'd0) idle_addr_bad++;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model(input logic [4:0] a, input logic [4:0] b);
        int s;
        logic [4:0] ai, bi;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            ai = a + i[4:0];
            bi = b + i[4:0];
            s += $signed(mem[ai]) * $signed(mem[bi]);
        end
        return s;
    endfunction

    // One full transaction: start, wait for result, handshake after `delay`
    // cycles. With noisy set, start stays high with changing bases while busy.
    task automatic run_dot(input logic [4:0] a, input logic [4:0] b,
                           input int delay, input bit noisy, input string tag);
        int edges;
        int exp;
        int bad;
        logic [4:0] ea, eb;
        exp = model(a, b);
        rd_log.delete();
        bus.start  = 1'b1;
        bus.a_base = a;
        bus.b_base = b;
        @(posedge clk);
        @(negedge clk);
        if (noisy) begin
            bus.a_base = 5'($urandom);
            bus.b_base = 5'($urandom);
        end else begin
            bus.start = 1'b0;
        end
        edges = 0;
        while (!bus.result_valid && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (noisy) begin
                bus.a_base = 5'($urandom);
                bus.b_base = 5'($urandom);
            end
        end
        check({tag, "_latency"}, edges, 24);
        check({tag, "_result"}, bus.result, exp);
        for (int d = 0; d < delay; d++) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.result_ready = 1'b0;
        bus.start = 1'b0;
        check({tag, "_idle_after"}, {bus.busy, bus.result_valid}, 0);
        check({tag, "_rd_count"}, rd_log.size(), 16);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            ea = a + i[4:0];
            eb = b + i[4:0];
            if (rd_log.size() != 16) bad++;
            else if (rd_log[2*i] != ea || rd_log[2*i+1] != eb) bad++;
        end
        check({tag, "_rd_addrs"}, bad, 0);
    endtask

    initial begin
        int bp_bad;
        int edges;
        logic signed [18:0] snap;

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a_base = '0;
        bus.b_base = '0;
        bus.result_ready = 1'b0;
        bus.mem_rd_data = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_valid", bus.result_valid, 0);
        check("reset_result", bus.result, 0);
        check("reset_rd_en", bus.mem_rd_en, 0);
        check("reset_rd_addr", bus.mem_rd_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sum: 1..8 dotted with all ones.
        for (int i = 0; i < 8; i++) begin
            mem[i]   = 8'(i + 1);
            mem[i+8] = 8'd1;
        end
        run_dot(5'd0, 5'd8, 0, 1'b0, "basic");
        check("basic_const", bus.result, 36);

        // Signed extremes.
        for (int i = 0; i < 8; i++) begin
            mem[i]    = 8'h80;
            mem[i+16] = 8'h80;
        end
        run_dot(5'd0, 5'd16, 1, 1'b0, "neg_x_neg");
        check("neg_x_neg_const", bus.result, 131072);
        for (int i = 0; i < 8; i++) mem[i] = 8'h7F;
        run_dot(5'd0, 5'd16, 0, 1'b0, "pos_x_neg");
        check("pos_x_neg_const", bus.result, -130048);

        // Backpressure in DONE with start pulsing.
        for (int i = 0; i < 8; i++) begin
            mem[i]   = 8'(i + 1);
            mem[i+8] = 8'd1;
        end
        bus.start = 1'b1;
        bus.a_base = 5'd0;
        bus.b_base = 5'd8;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        edges = 0;
        while (!bus.result_valid && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("bp_latency", edges, 24);
        snap = bus.result;
        check("bp_result", snap, 36);
        bp_bad = 0;
        for (int c = 0; c < 10; c++) begin
            bus.start  = c[0];
            bus.a_base = 5'($urandom);
            bus.b_base = 5'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (bus.result !== snap || !bus.result_valid || !bus.busy || bus.mem_rd_en)
                bp_bad++;
        end
        check("bp_hold", bp_bad, 0);
        bus.start = 1'b1;
        bus.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.result_ready = 1'b0;
        bus.start = 1'b0;
        check("bp_release", {bus.busy, bus.result_valid}, 0);
        bp_bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.busy || bus.mem_rd_en) bp_bad++;
        end
        check("bp_no_refetch", bp_bad, 0);
        check("bp_result_kept", bus.result, 36);

        // Address wrap.
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        run_dot(5'd28, 5'd12, 2, 1'b0, "wrap");

        // Reset mid-operation, then a clean run.
        bus.start = 1'b1;
        bus.a_base = 5'd3;
        bus.b_base = 5'd20;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_valid", bus.result_valid, 0);
        check("rst_mid_result", bus.result, 0);
        check("rst_mid_rd_en", bus.mem_rd_en, 0);
        check("rst_mid_rd_addr", bus.mem_rd_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_dot(5'd3, 5'd20, 0, 1'b0, "after_rst");

        // Back-to-back random runs.
        for (int r = 0; r < 100; r++) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
            run_dot(5'($urandom), 5'($urandom), int'($urandom_range(0, 5)), 1'b1,
                    $sformatf("rand%0d", r));
        end

        check("idle_addr_zero", idle_addr_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dot_product_engine.md
# dot_product_engine

Sequencing and multiply-accumulate stage of the dot-product datapath; sits directly downstream of the vector memory and drives that memory's read port. On a start request it fetches element pairs A[i], B[i] from two base addresses, accumulates their signed products over VEC_LEN elements, and presents the sum through a valid/ready result handshake. It uses one shared read port with one-cycle registered read latency, so element reads are time-multiplexed.

## Interface
- DATA_WIDTH, 8, element width; signed two's complement.
- ADDR_WIDTH, 5, memory address width.
- VEC_LEN, 8, elements per vector; must be 2 or more.
- ACC_WIDTH, 19, accumulator/result width; must be at least 2*DATA_WIDTH + clog2(VEC_LEN).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a dot product; sampled only in IDLE.
- a_base  in  ADDR_WIDTH  address of A[0]; latched when start is accepted.
- b_base  in  ADDR_WIDTH  address of B[0]; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  ADDR_WIDTH  memory read address.
- mem_rd_data  in  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en.
- result  out  ACC_WIDTH  signed dot product.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.

## Operation
- States: IDLE, FETCH_A, FETCH_B, MAC, DONE. A 1-bit-wider-than-needed index counter idx runs from 0 to VEC_LEN-1.
- **IDLE:** when start=1, latch a_base and b_base, clear acc and idx, then go to FETCH_A. Otherwise stay in IDLE.
- **FETCH_A:** mem_rd_en=1 and mem_rd_addr=a_base+idx. Go to FETCH_B.
- **FETCH_B:** mem_rd_en=1 and mem_rd_addr=b_base+idx. Capture mem_rd_data (A[idx]) into a_reg. Go to MAC.
- **MAC:** mem_rd_en=0. Compute prod = signed(a_reg) * signed(mem_rd_data), sign-extended to ACC_WIDTH.
  - If idx<VEC_LEN-1: acc<=acc+prod, idx<=idx+1, go to FETCH_A.
  - Otherwise: result<=acc+prod, go to DONE.
- **DONE:** result_valid=1. On result_ready=1, go to IDLE. Otherwise hold.
- mem_rd_en and mem_rd_addr are combinational decodes of state, idx and the latched bases. mem_rd_addr is 0 when mem_rd_en=0.
- Address arithmetic is modulo 2^ADDR_WIDTH, so a vector may wrap from address 2^ADDR_WIDTH-1 to 0.
- No overflow is possible given the ACC_WIDTH constraint, and no saturation is applied.
- start is ignored outside IDLE, including in the DONE cycle where the handshake completes.
- result and result_valid stay stable while in DONE. result holds its last value after the handshake, until the next completion overwrites it.
- **Reset, at any time including mid-operation:** state=IDLE, idx=0, acc=0, a_reg=0, result=0, result_valid=0, busy=0, mem_rd_en=0, mem_rd_addr=0. A computation interrupted by reset produces no result.

## Timing
- Edge E0 samples start=1 in IDLE.
- Element i occupies three cycles:
  - FETCH_A in cycle 3i+1, the cycle after edge E(3i).
  - FETCH_B in cycle 3i+2.
  - MAC in cycle 3i+3.
- result_valid rises after edge E(3*VEC_LEN). For default VEC_LEN=8, that is 24 cycles after the start edge.
- The handshake completes on the edge where result_valid=1 and result_ready=1. busy and result_valid are low in the following cycle.
- result_ready held high beforehand gives a one-cycle DONE.
- The earliest next start is sampled one cycle after the handshake edge. Minimum back-to-back period is 3*VEC_LEN+2 cycles.
- Memory read latency is exactly one cycle. a_reg samples A data during FETCH_B, and the MAC sample is B data.

## Test plan
- **Basic sum:** memory 0..7 = 1..8, memory 8..15 = 1; start with a_base=0, b_base=8 → result=36, result_valid 24 cycles after start. Exactly 16 mem_rd_en cycles, with addresses 0,8,1,9,…,7,15.
- **Signed extremes:**
  - A all 0x80, B all 0x80 → result=131072.
  - A all 0x7F, B all 0x80 → result=-130048 (two's complement, 19 bits).
- **Backpressure:** hold result_ready=0 for 10 cycles in DONE and pulse start → result, result_valid and busy stay stable; mem_rd_en=0; start is ignored. Asserting ready returns the block to IDLE with no new fetch.
- **Address wrap:** a_base=28, b_base=12 → A reads at 28,29,30,31,0,1,2,3 and B reads at 12..19; sum matches the reference model.
- **Reset mid-operation:** assert rst_n=0 for one cycle at cycle 10 after start → all outputs 0 the next cycle. A fresh start then returns the correct result with no residue from the aborted run.
- **Back-to-back with random data:** 100 random vector pairs and bases, random result_ready delays 0–5 cycles, start re-asserted as soon as busy=0 → every result matches the model. start asserted while busy never alters the latched bases.
